// File: rtl/fib_term_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fib_term_buffer_if
// Description : Valid/ready output stream of the Fibonacci term buffer.
//               The master drives head term/index and valid, and the slave
//               drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface fib_term_buffer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_term;
    logic [WIDTH-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_term,
        output out_idx,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_term,
        input  out_idx,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fib_term_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fib_term_buffer
// Description : Captures each new term from the Fibonacci generator into a
//               small FIFO and drains it through a valid/ready stream.
//               Flags sequence restarts (seq_done) and dropped captures
//               (overflow, sticky). The optional macro FIB_SEQ_CHECK_EN adds
//               a sticky recurrence checker (chk_err). Without the macro,
//               chk_err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_term_buffer #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [WIDTH-1:0]  term_in,
    input  wire logic [WIDTH-1:0]  idx_in,
    fib_term_buffer_if.master      out_bus,
    output logic [LVL_W-1:0]       level,
    output logic                   seq_done,
    output logic                   overflow,
    output logic                   chk_err
);

    localparam int                c_PTR_W   = $clog2(DEPTH);
    localparam logic [LVL_W-1:0]  c_DEPTH   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  c_LVL_ONE = LVL_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [WIDTH-1:0]   r_mem_term [DEPTH];
    logic [WIDTH-1:0]   r_mem_idx  [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [WIDTH-1:0]   r_last_idx;
    logic               r_seq_done;
    logic               r_overflow;

    logic w_cap;
    logic w_rst_seq;
    logic w_pop;
    logic w_push;
    logic w_valid;

    // A new non-zero index marks a fresh term; index 0 after non-zero is a restart.
    assign w_cap     = (idx_in != r_last_idx) && (idx_in != '0);
    assign w_rst_seq = (idx_in == '0) && (r_last_idx != '0);
    assign w_valid   = (r_level != '0);
    assign w_pop     = w_valid && out_bus.out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push    = w_cap && ((r_level < c_DEPTH) || w_pop);

    assign out_bus.out_term  = r_mem_term[r_rd_ptr];
    assign out_bus.out_idx   = r_mem_idx[r_rd_ptr];
    assign out_bus.out_valid = w_valid;
    assign level             = r_level;
    assign seq_done          = r_seq_done;
    assign overflow          = r_overflow;

    // FIFO storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_term[i] <= '0;
                r_mem_idx[i]  <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem_term[r_wr_ptr] <= term_in;
                r_mem_idx[r_wr_ptr]  <= idx_in;
                r_wr_ptr             <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Index history, restart pulse and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_idx <= '0;
            r_seq_done <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_last_idx <= idx_in;
            r_seq_done <= w_rst_seq;
            if (w_cap && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef FIB_SEQ_CHECK_EN
    logic [WIDTH-1:0] r_prev1;
    logic [WIDTH-1:0] r_prev2;
    logic [1:0]       r_hist_cnt;
    logic             r_chk_err;
    logic [WIDTH-1:0] w_sum;

    assign w_sum   = r_prev1 + r_prev2;
    assign chk_err = r_chk_err;

    // Recurrence check; history follows every capture, dropped ones included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev1    <= '0;
            r_prev2    <= '0;
            r_hist_cnt <= 2'd0;
            r_chk_err  <= 1'b0;
        end else if (w_rst_seq) begin
            r_hist_cnt <= 2'd0;
        end else if (w_cap) begin
            if ((r_hist_cnt == 2'd2) && (term_in != w_sum)) begin
                r_chk_err <= 1'b1;
            end
            r_prev2 <= r_prev1;
            r_prev1 <= term_in;
            if (r_hist_cnt != 2'd2) begin
                r_hist_cnt <= r_hist_cnt + 2'd1;
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/fib_term_buffer.md
Name: fib_term_buffer

Overview:
Downstream consumer of the Fibonacci generator stage. Samples the generator's latest term and step counter every cycle and captures each new term into a small FIFO. Drains the FIFO through a valid/ready interface to the next stage. Flags sequence restarts, FIFO overflow and, optionally, recurrence violations.

Parameters:
WIDTH, 8, bit width of terms and of the index.
DEPTH, 8, FIFO entries; power of two, at least 2.
LVL_W, $clog2(DEPTH)+1, derived width of the level output; not overridden.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
term_in  input  WIDTH  latest term from the generator (its fib2).
idx_in  input  WIDTH  generator step counter (its count); 0 marks the start or restart of a sequence.
out_term  output  WIDTH  term at the FIFO head.
out_idx  output  WIDTH  index captured with the head term.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  downstream accepts the head entry.
level  output  LVL_W  current occupancy, 0..DEPTH.
seq_done  output  1  one-cycle pulse when a sequence restarts.
overflow  output  1  sticky; a capture was dropped because the FIFO was full.
chk_err  output  1  sticky recurrence error; exists only with FIB_SEQ_CHECK_EN.

Behaviour:
- Reset (rst=1 at an edge) clears all state. Values after reset:
  - out_valid=0, level=0, out_term=0, out_idx=0.
  - seq_done=0, overflow=0, chk_err=0.
  - last_idx=0, history count=0.
  - Reset mid-stream discards all FIFO contents.
- last_idx register is loaded with idx_in every cycle.
- Capture: cap = (idx_in != last_idx) && (idx_in != 0), evaluated combinationally each cycle.
  - A held idx produces exactly one capture.
- Restart: rst_seq = (idx_in == 0) && (last_idx != 0).
  - seq_done=1 in the cycle after the edge that sees rst_seq; otherwise 0.
  - History count is cleared. FIFO contents and sticky flags are kept.
- Pop: pop = out_valid && out_ready. The head advances at the edge.
- Push: push = cap && (level < DEPTH || pop). It writes {idx_in, term_in} at the tail.
- Push and pop in the same cycle leave level unchanged. This holds at full and at level 1.
- At empty, a push makes out_valid=1 in the next cycle; capture-to-output latency is 1 cycle.
  - FIFO is not bypassed; at empty, out_valid is never high in the capture cycle.
- cap while full with no pop: the entry is dropped, overflow is set to 1 and held until rst.
- out_term and out_idx are stable while out_valid=1 and out_ready=0.
- Pointers wrap modulo DEPTH.
- Arithmetic is unsigned, modulo 2^WIDTH. Terms are captured as presented; no saturation.

Optional Feature:
FIB_SEQ_CHECK_EN
- Defined:
  - Keeps prev1/prev2 history registers and a history count (0..2), updated on every cap, including dropped ones.
  - When history count==2 and term_in != (prev1+prev2) mod 2^WIDTH, chk_err is set at that edge and held until rst.
  - rst_seq clears the history count, so the first two terms of each sequence are never checked.
- Undefined:
  - No history registers exist; chk_err is tied to 0.
  - All other behaviour is identical.

Test Plan:
- After rst: idx_in 1,2,3,4,5 with term_in 1,2,3,5,8, one per cycle, out_ready=1 -> out_valid rises one cycle after the first capture; out pairs (1,1),(2,2),(3,3),(4,5),(5,8) in order; chk_err=0, overflow=0.
- idx_in held at 3 for 4 cycles with term 3 -> exactly one entry pushed; level goes 0->1.
- out_ready=0, 10 distinct captures, DEPTH=8:
  - level=8, overflow=1.
  - Entries 9 and 10 are lost; draining yields the first 8 in order.
  - overflow stays 1 after the drain.
- FIFO full, out_ready=1 and a new capture in the same cycle -> level stays 8, head advances, overflow stays 0.
- Terms 1,2,4 at idx 1,2,3 -> chk_err=1 after the third edge when FIB_SEQ_CHECK_EN is defined; stays 0 when it is not.
- Restart and wrap:
  - idx 5 -> 0 -> seq_done high for exactly 1 cycle.
  - Then idx 1,2 with terms 1,1 -> no chk_err, since history was cleared.
  - Terms 144, 233, 121 (377 mod 256) -> accepted, no chk_err.
  - rst asserted mid-stream -> next cycle level=0, out_valid=0, all flags 0.
